eh2_dec_trigger_csr: RTL and testbench

//  Per-thread debug-trigger CSR file (tselect/tdata1/tdata2, mcontrol type 2) on the TLU side.

---
 rtl/eh2_dec_trigger_csr.sv | 183 ++++++++++++++++++
 tb/tb_eh2_dec_trigger_csr.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/eh2_dec_trigger_csr.sv
// rtl/eh2_dec_trigger_csr.sv - per-thread debug trigger CSR file (tselect/tdata1/tdata2, mcontrol type 2)

package eh2_pkg;

  // Core parameter bundle; only NUM_THREADS is consumed here.
  typedef struct packed {
    logic [3:0] NUM_THREADS;
  } eh2_param_t;

  // Trigger packet handed to the decode/LSU matchers.
  typedef struct packed {
    logic        select;
    logic        match;
    logic        store;
    logic        load;
    logic        execute;
    logic        m;
    logic [31:0] tdata2;
  } eh2_trigger_pkt_t;

  // Writable tdata1 fields of one mcontrol trigger.
  typedef struct packed {
    logic dmode;
    logic hit;
    logic select;
    logic action;
    logic chain;
    logic match;
    logic m;
    logic execute;
    logic store;
    logic load;
  } eh2_trig_ctl_t;

endpackage

module eh2_dec_trigger_csr
  import eh2_pkg::*;
#(
  parameter eh2_param_t pt = '{NUM_THREADS: 4'd2}
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic [pt.NUM_THREADS-1:0]                 dbg_mode,
  input  logic [pt.NUM_THREADS-1:0]                 mstatus_mie,
  input  logic                                      csr_wr_en,
  input  logic                                      csr_wr_tid,
  input  logic [11:0]                               csr_wr_addr,
  input  logic [31:0]                               csr_wr_data,
  input  logic                                      csr_rd_tid,
  input  logic [11:0]                               csr_rd_addr,
  output logic [31:0]                               csr_rd_data,
  output logic                                      csr_rd_hit,
  input  logic [pt.NUM_THREADS-1:0][3:0]            update_hit,
  output eh2_trigger_pkt_t [pt.NUM_THREADS-1:0][3:0] trigger_pkt_any
);

  localparam int NT = int'(pt.NUM_THREADS);

  localparam logic [11:0] ADDR_TSELECT = 12'h7A0;
  localparam logic [11:0] ADDR_TDATA1  = 12'h7A1;
  localparam logic [11:0] ADDR_TDATA2  = 12'h7A2;

  logic [1:0]    mtsel   [NT];
  eh2_trig_ctl_t td1     [NT][4];
  eh2_trig_ctl_t td1_nxt [NT][4];
  logic [31:0]   td2     [NT][4];

  logic [NT-1:0]      wr_tsel;
  logic [NT-1:0][3:0] wr_td1;
  logic [NT-1:0][3:0] wr_td2;

  // Decode the write strobe per thread/trigger, applying debug-mode and chain-pair locks.
  always_comb begin
    logic wr_thr;
    logic lock;
    logic pair_lock;
    wr_tsel   = '0;
    wr_td1    = '0;
    wr_td2    = '0;
    wr_thr    = 1'b0;
    lock      = 1'b0;
    pair_lock = 1'b0;
    for (int t = 0; t < NT; t++) begin
      // A single-thread build ignores the thread id entirely.
      wr_thr     = csr_wr_en & ((NT == 1) | (csr_wr_tid == 1'(t)));
      wr_tsel[t] = wr_thr & (csr_wr_addr == ADDR_TSELECT);
      for (int i = 0; i < 4; i++) begin
        lock = td1[t][i].dmode & ~dbg_mode[t];
        // Even triggers head a chain pair; a debug-owned odd partner freezes the head too.
        pair_lock = (i[0] == 1'b0) ? (td1[t][i | 1].dmode & ~dbg_mode[t]) : 1'b0;
        wr_td1[t][i] = wr_thr & (csr_wr_addr == ADDR_TDATA1) & (mtsel[t] == 2'(i))
                     & ~lock & ~pair_lock;
        wr_td2[t][i] = wr_thr & (csr_wr_addr == ADDR_TDATA2) & (mtsel[t] == 2'(i)) & ~lock;
      end
    end
  end

  // Next tdata1 value: CSR write fields, with hardware hit recording OR-ed on top.
  always_comb begin
    for (int t = 0; t < NT; t++) begin
      for (int i = 0; i < 4; i++) begin
        td1_nxt[t][i] = td1[t][i];
        if (wr_td1[t][i]) begin
          td1_nxt[t][i].dmode   = csr_wr_data[27] & dbg_mode[t];
          td1_nxt[t][i].hit     = csr_wr_data[20];
          td1_nxt[t][i].select  = csr_wr_data[19];
          td1_nxt[t][i].action  = csr_wr_data[12];
          td1_nxt[t][i].chain   = (i[0] == 1'b0) ? csr_wr_data[11] : 1'b0;
          td1_nxt[t][i].match   = csr_wr_data[7];
          td1_nxt[t][i].m       = csr_wr_data[6];
          td1_nxt[t][i].execute = csr_wr_data[2];
          td1_nxt[t][i].store   = csr_wr_data[1];
          td1_nxt[t][i].load    = csr_wr_data[0];
        end
        td1_nxt[t][i].hit = td1_nxt[t][i].hit | update_hit[t][i];
      end
    end
  end

  // Trigger state registers; reset clears everything regardless of a pending write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int t = 0; t < NT; t++) begin
        mtsel[t] <= '0;
        for (int i = 0; i < 4; i++) begin
          td1[t][i] <= '0;
          td2[t][i] <= '0;
        end
      end
    end else begin
      for (int t = 0; t < NT; t++) begin
        if (wr_tsel[t]) mtsel[t] <= csr_wr_data[1:0];
        for (int i = 0; i < 4; i++) begin
          td1[t][i] <= td1_nxt[t][i];
          if (wr_td2[t][i]) td2[t][i] <= csr_wr_data;
        end
      end
    end
  end

  // Packet mirrors the registered CSR state; breakpoint triggers are muted while MIE=0.
  always_comb begin
    for (int t = 0; t < NT; t++) begin
      for (int i = 0; i < 4; i++) begin
        trigger_pkt_any[t][i].select  = td1[t][i].select;
        trigger_pkt_any[t][i].match   = td1[t][i].match;
        trigger_pkt_any[t][i].store   = td1[t][i].store;
        trigger_pkt_any[t][i].load    = td1[t][i].load;
        trigger_pkt_any[t][i].execute = td1[t][i].execute;
        trigger_pkt_any[t][i].m       = td1[t][i].m & (td1[t][i].action | mstatus_mie[t]);
        trigger_pkt_any[t][i].tdata2  = td2[t][i];
      end
    end
  end

  assign csr_rd_hit = (csr_rd_addr == ADDR_TSELECT) | (csr_rd_addr == ADDR_TDATA1) |
                      (csr_rd_addr == ADDR_TDATA2);

  // Combinational read mux for the selected thread's currently selected trigger.
  always_comb begin
    logic [1:0]    rsel;
    eh2_trig_ctl_t rtd;
    csr_rd_data = '0;
    rsel        = '0;
    rtd         = '0;
    for (int t = 0; t < NT; t++) begin
      if ((NT == 1) || (csr_rd_tid == 1'(t))) begin
        rsel = mtsel[t];
        rtd  = td1[t][rsel];
        case (csr_rd_addr)
          ADDR_TSELECT: csr_rd_data = {30'b0, rsel};
          ADDR_TDATA1:  csr_rd_data = {4'h2, rtd.dmode, 6'd31, rtd.hit, rtd.select, 1'b0, 5'b0,
                                       rtd.action, rtd.chain, 3'b0, rtd.match, rtd.m, 1'b0, 2'b0,
                                       rtd.execute, rtd.store, rtd.load};
          ADDR_TDATA2:  csr_rd_data = td2[t][rsel];
          default:      csr_rd_data = '0;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_eh2_dec_trigger_csr.sv
// tb/tb_eh2_dec_trigger_csr.sv - directed bench for eh2_dec_trigger_csr
module tb_eh2_dec_trigger_csr;
  import eh2_pkg::*;

  logic                       clk;
  logic                       rst;
  logic [1:0]                 dbg_mode;
  logic [1:0]                 mstatus_mie;
  logic                       csr_wr_en;
  logic                       csr_wr_tid;
  logic [11:0]                csr_wr_addr;
  logic [31:0]                csr_wr_data;
  logic                       csr_rd_tid;
  logic [11:0]                csr_rd_addr;
  logic [31:0]                csr_rd_data;
  logic                       csr_rd_hit;
  logic [1:0][3:0]            update_hit;
  eh2_trigger_pkt_t [1:0][3:0] trigger_pkt_any;

  int checks;
  int failures;

  eh2_dec_trigger_csr dut (
    .clk             (clk),
    .rst             (rst),
    .dbg_mode        (dbg_mode),
    .mstatus_mie     (mstatus_mie),
    .csr_wr_en       (csr_wr_en),
    .csr_wr_tid      (csr_wr_tid),
    .csr_wr_addr     (csr_wr_addr),
    .csr_wr_data     (csr_wr_data),
    .csr_rd_tid      (csr_rd_tid),
    .csr_rd_addr     (csr_rd_addr),
    .csr_rd_data     (csr_rd_data),
    .csr_rd_hit      (csr_rd_hit),
    .update_hit      (update_hit),
    .trigger_pkt_any (trigger_pkt_any)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One CSR write cycle, driven and released on falling edges.
  task automatic wr(input logic tid, input logic [11:0] addr, input logic [31:0] data);
    @(negedge clk);
    csr_wr_en   = 1'b1;
    csr_wr_tid  = tid;
    csr_wr_addr = addr;
    csr_wr_data = data;
    @(negedge clk);
    csr_wr_en   = 1'b0;
  endtask

  // Set up a combinational read and let it settle.
  task automatic rd(input logic tid, input logic [11:0] addr);
    csr_rd_tid  = tid;
    csr_rd_addr = addr;
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (trigger_pkt_any !== '0) begin
      failures++;
      $display("FAIL reset_pkt got=%h exp=0", trigger_pkt_any);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      wr(1'b0, 12'h7A0, 32'(i));
      rd(1'b0, 12'h7A1);
      checks++;
      if (csr_rd_data !== 32'h23E00000) begin
        failures++;
        $display("FAIL reset_tdata1_%0d got=%h exp=23e00000", i, csr_rd_data);
      end
    end
    rd(1'b1, 12'h7A0);
    checks++;
    if (csr_rd_data !== 32'h0 || csr_rd_hit !== 1'b1) begin
      failures++;
      $display("FAIL reset_tselect_t1 got=%h hit=%b exp=0 hit=1", csr_rd_data, csr_rd_hit);
    end
    rd(1'b0, 12'h300);
    checks++;
    if (csr_rd_hit !== 1'b0 || csr_rd_data !== 32'h0) begin
      failures++;
      $display("FAIL rd_hit_other got=%b data=%h exp=0 data=0", csr_rd_hit, csr_rd_data);
    end
  endtask

  task automatic test_program;
    mstatus_mie = 2'b11;
    wr(1'b0, 12'h7A0, 32'd2);
    wr(1'b0, 12'h7A1, 32'h00000045);
    @(negedge clk);
    csr_wr_en   = 1'b1;
    csr_wr_tid  = 1'b0;
    csr_wr_addr = 12'h7A2;
    csr_wr_data = 32'h80000000;
    #1;
    checks++;
    if (trigger_pkt_any[0][2].tdata2 !== 32'h0) begin
      failures++;
      $display("FAIL pkt_before_edge got=%h exp=0", trigger_pkt_any[0][2].tdata2);
    end
    @(negedge clk);
    csr_wr_en = 1'b0;
    checks++;
    if (trigger_pkt_any[0][2] !== {1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'h80000000}) begin
      failures++;
      $display("FAIL pkt_t0_tr2 got=%h exp=%h", trigger_pkt_any[0][2],
               {1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'h80000000});
    end
    rd(1'b0, 12'h7A1);
    checks++;
    if (csr_rd_data !== 32'h23E00045) begin
      failures++;
      $display("FAIL tdata1_t0_tr2 got=%h exp=23e00045", csr_rd_data);
    end
    rd(1'b0, 12'h7A0);
    checks++;
    if (csr_rd_data !== 32'h2) begin
      failures++;
      $display("FAIL tselect_t0 got=%h exp=2", csr_rd_data);
    end
    checks++;
    if (trigger_pkt_any[1] !== '0) begin
      failures++;
      $display("FAIL thread1_untouched got=%h exp=0", trigger_pkt_any[1]);
    end
  endtask

  task automatic test_dmode_lock;
    dbg_mode = 2'b01;
    wr(1'b0, 12'h7A0, 32'd1);
    wr(1'b0, 12'h7A1, 32'h08000044);
    wr(1'b0, 12'h7A2, 32'h00001234);
    dbg_mode = 2'b00;
    wr(1'b0, 12'h7A1, 32'h0);
    wr(1'b0, 12'h7A2, 32'h0);
    rd(1'b0, 12'h7A1);
    checks++;
    if (csr_rd_data !== 32'h2BE00044) begin
      failures++;
      $display("FAIL dmode_lock_tdata1 got=%h exp=2be00044", csr_rd_data);
    end
    rd(1'b0, 12'h7A2);
    checks++;
    if (csr_rd_data !== 32'h00001234) begin
      failures++;
      $display("FAIL dmode_lock_tdata2 got=%h exp=00001234", csr_rd_data);
    end
    // Trigger 0 is locked by its debug-owned partner, trigger 1.
    wr(1'b0, 12'h7A0, 32'd0);
    wr(1'b0, 12'h7A1, 32'h00000045);
    rd(1'b0, 12'h7A1);
    checks++;
    if (csr_rd_data !== 32'h23E00000) begin
      failures++;
      $display("FAIL chain_pair_lock got=%h exp=23e00000", csr_rd_data);
    end
    // dmode cannot be set outside debug mode.
    wr(1'b1, 12'h7A1, 32'h08000004);
    rd(1'b1, 12'h7A1);
    checks++;
    if (csr_rd_data !== 32'h23E00004) begin
      failures++;
      $display("FAIL dmode_no_dbg got=%h exp=23e00004", csr_rd_data);
    end
  endtask

  task automatic test_chain;
    wr(1'b1, 12'h7A0, 32'd1);
    wr(1'b1, 12'h7A1, 32'h00000800);
    rd(1'b1, 12'h7A1);
    checks++;
    if (csr_rd_data !== 32'h23E00000) begin
      failures++;
      $display("FAIL chain_tr1 got=%h exp=23e00000", csr_rd_data);
    end
    wr(1'b1, 12'h7A0, 32'd0);
    wr(1'b1, 12'h7A1, 32'h00000800);
    rd(1'b1, 12'h7A1);
    checks++;
    if (csr_rd_data !== 32'h23E00800) begin
      failures++;
      $display("FAIL chain_tr0 got=%h exp=23e00800", csr_rd_data);
    end
  endtask

  task automatic test_hit;
    wr(1'b0, 12'h7A0, 32'd3);
    @(negedge clk);
    csr_wr_en        = 1'b1;
    csr_wr_tid       = 1'b0;
    csr_wr_addr      = 12'h7A1;
    csr_wr_data      = 32'h00000004;
    update_hit       = '0;
    update_hit[0][3] = 1'b1;
    @(negedge clk);
    csr_wr_en  = 1'b0;
    update_hit = '0;
    rd(1'b0, 12'h7A1);
    checks++;
    if (csr_rd_data !== 32'h23F00004) begin
      failures++;
      $display("FAIL hit_merge got=%h exp=23f00004", csr_rd_data);
    end
    @(negedge clk);
    update_hit[1][2] = 1'b1;
    @(negedge clk);
    update_hit = '0;
    wr(1'b1, 12'h7A0, 32'd2);
    rd(1'b1, 12'h7A1);
    checks++;
    if (csr_rd_data !== 32'h23F00000) begin
      failures++;
      $display("FAIL hit_update_only got=%h exp=23f00000", csr_rd_data);
    end
    wr(1'b1, 12'h7A1, 32'h0);
    rd(1'b1, 12'h7A1);
    checks++;
    if (csr_rd_data !== 32'h23E00000) begin
      failures++;
      $display("FAIL hit_clear got=%h exp=23e00000", csr_rd_data);
    end
  endtask

  task automatic test_mie;
    mstatus_mie = 2'b11;
    #1;
    checks++;
    if (trigger_pkt_any[0][2].m !== 1'b1) begin
      failures++;
      $display("FAIL mie1_m got=%b exp=1", trigger_pkt_any[0][2].m);
    end
    mstatus_mie = 2'b10;
    #1;
    checks++;
    if (trigger_pkt_any[0][2].m !== 1'b0) begin
      failures++;
      $display("FAIL mie0_m got=%b exp=0", trigger_pkt_any[0][2].m);
    end
    wr(1'b0, 12'h7A0, 32'd2);
    wr(1'b0, 12'h7A1, 32'h00001045);
    checks++;
    if (trigger_pkt_any[0][2].m !== 1'b1) begin
      failures++;
      $display("FAIL action_m got=%b exp=1", trigger_pkt_any[0][2].m);
    end
    rd(1'b0, 12'h7A1);
    checks++;
    if (csr_rd_data !== 32'h23E01045) begin
      failures++;
      $display("FAIL action_tdata1 got=%h exp=23e01045", csr_rd_data);
    end
    mstatus_mie = 2'b11;
  endtask

  task automatic test_back_to_back;
    @(negedge clk);
    csr_wr_en   = 1'b1;
    csr_wr_tid  = 1'b1;
    csr_wr_addr = 12'h7A0;
    csr_wr_data = 32'd3;
    @(negedge clk);
    csr_wr_addr = 12'h7A2;
    csr_wr_data = 32'hA5A50001;
    @(negedge clk);
    csr_wr_addr = 12'h7A1;
    csr_wr_data = 32'h00080083;
    @(negedge clk);
    csr_wr_en = 1'b0;
    checks++;
    if (trigger_pkt_any[1][3] !== {1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'hA5A50001}) begin
      failures++;
      $display("FAIL b2b_pkt got=%h exp=%h", trigger_pkt_any[1][3],
               {1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'hA5A50001});
    end
    rd(1'b0, 12'h7A2);
    checks++;
    if (csr_rd_data !== 32'h80000000) begin
      failures++;
      $display("FAIL b2b_other_thread got=%h exp=80000000", csr_rd_data);
    end
  endtask

  task automatic test_reset_mid_write;
    @(negedge clk);
    csr_wr_en   = 1'b1;
    csr_wr_tid  = 1'b0;
    csr_wr_addr = 12'h7A2;
    csr_wr_data = 32'hFFFFFFFF;
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (trigger_pkt_any !== '0) begin
      failures++;
      $display("FAIL async_reset_pkt got=%h exp=0", trigger_pkt_any);
    end
    @(negedge clk);
    checks++;
    if (trigger_pkt_any !== '0) begin
      failures++;
      $display("FAIL reset_wins_pkt got=%h exp=0", trigger_pkt_any);
    end
    rd(1'b0, 12'h7A0);
    checks++;
    if (csr_rd_data !== 32'h0) begin
      failures++;
      $display("FAIL reset_wins_tselect got=%h exp=0", csr_rd_data);
    end
    csr_wr_en = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    checks      = 0;
    failures    = 0;
    rst         = 1'b1;
    dbg_mode    = '0;
    mstatus_mie = '0;
    csr_wr_en   = 1'b0;
    csr_wr_tid  = 1'b0;
    csr_wr_addr = '0;
    csr_wr_data = '0;
    csr_rd_tid  = 1'b0;
    csr_rd_addr = 12'h7A1;
    update_hit  = '0;
    test_reset;
    test_program;
    test_dmode_lock;
    test_chain;
    test_hit;
    test_mie;
    test_back_to_back;
    test_reset_mid_write;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
